phy_rx_unstripe: RTL and testbench
==================================

Name: phy_rx_unstripe

Overview:
- Receive-side counterpart of the PHY transmit path.
- Accepts two 8-bit lanes, each with its own valid, and packs every 4 valid bytes of a lane into a 32-bit word.
- Buffers the packed words per lane, then un-stripes them back into one 32-bit stream, alternating lane 0 then lane 1.
- Sits between the per-lane byte receivers and the 32-bit receive consumer.

Parameters:
- FIFO_DEPTH, 4, words buffered per lane after packing; power of 2, minimum 2.
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk_4f  input  1  single clock; byte rate of each lane.
- reset  input  1  asynchronous, active-high; clears all state.
- data_in_0  input  8  lane 0 byte.
- valid_in0  input  1  lane 0 byte qualifier.
- data_in_1  input  8  lane 1 byte.
- valid_in1  input  1  lane 1 byte qualifier.
- data_out  output  32  un-striped word.
- valid_out  output  1  data_out qualifier; high for exactly one cycle per word.
- overflow_err  output  1  sticky; a lane FIFO dropped a word.

Behaviour:
- Reset (async assert, sync release):
  - data_out=0, valid_out=0, overflow_err=0.
  - Both byte counters=0, both FIFOs empty, un-stripe state=EXP_L0.
  - Reset mid-word discards all partial bytes and buffered words.
- Per-lane packer, one per lane, independent:
  - 2-bit byte counter plus 24-bit shift register.
  - The counter advances only on an edge where valid_inN=1; invalid cycles pause packing and do not reset the counter.
  - Byte order is MSB first: the 1st valid byte goes to [31:24], the 4th to [7:0].
  - On the edge that samples the 4th byte, {shift, data_in_N} is written into FIFO N and the counter wraps to 0.
- Lane FIFO:
  - Synchronous, FIFO_DEPTH entries, PTR_W+1-bit occupancy count.
  - Push when full with no pop in the same cycle: the word is discarded, overflow_err is set and stays set until reset, and the pointers are unchanged.
  - Push when full with a pop in the same cycle: the push is accepted and occupancy stays at FIFO_DEPTH.
  - Push when empty with a pop in the same cycle: not possible, because a pop requires non-empty at the edge.
- Un-stripe FSM, states EXP_L0 and EXP_L1:
  - EXP_L0: if FIFO0 is non-empty, pop FIFO0, register its head into data_out, valid_out=1, go to EXP_L1. Otherwise valid_out=0 and stay.
  - EXP_L1: same, using FIFO1, then return to EXP_L0.
  - Strict alternation: a non-empty FIFO for the other lane never bypasses the expected lane. Lane 1 words wait, up to overflow, until the matching lane 0 word arrives.
  - When valid_out=0, data_out holds its previous value.
- Latency:
  - 4th byte of a lane presented in cycle k; FIFO written at the end of cycle k.
  - If that lane is expected and its FIFO was empty, data_out/valid_out are visible in cycle k+2.
  - Throughput: at most one word per cycle. Sustained input is 2 words per 4 cycles, so no overflow at nominal rate with balanced lanes.
- Simultaneous completion on both lanes in the same cycle: both FIFOs are written. Output order is L0 word in cycle k+2 and L1 word in cycle k+3, given the FSM is in EXP_L0.

Test Plan:
- Lane 0 bytes 0x11,0x22,0x33,0x44 and lane 1 bytes 0xAA,0xBB,0xCC,0xDD, both valid in cycles 0-3 -> data_out=0x11223344 in cycle 5 with valid_out=1, then 0xAABBCCDD in cycle 6. valid_out=0 in all other cycles; overflow_err=0.
- Lane 0 with valid gaps: bytes 0x01 in cycle 0, 0x02 in cycle 2, 0x03 in cycle 3, 0x04 in cycle 6 (valid_in0=0 in cycles 1, 4, 5) -> single word 0x01020304 in cycle 8.
- Lane 1 only, sending 4 words (16 bytes) while lane 0 is idle -> valid_out stays 0. Then one lane 0 word 0xCAFEF00D -> output 0xCAFEF00D, then the first lane 1 word the cycle after, then the FSM waits in EXP_L0.
- Lane 1 only, sending 5 words with FIFO_DEPTH=4 -> overflow_err=1 after the 5th word's completing edge. Subsequent lane 0 traffic drains exactly the first 4 lane 1 words in order; overflow_err stays 1 until reset.
- Reset asserted asynchronously mid-edge-interval after 2 bytes of a lane 0 word, with 1 word queued in FIFO1 -> all outputs 0 immediately. After release, a fresh 4-byte lane 0 word 0x55667788 is output intact with no stale bytes, and the old FIFO1 word never appears.
- Continuous balanced traffic, 64 words per lane with incrementing patterns -> output sequence strictly L0[i], L1[i] for i=0..63; overflow_err=0; the scoreboard matches all 128 words.

Source files
------------

// File: rtl/phy_rx_unstripe.sv
// Receive un-striper: packs each lane's bytes MSB-first into 32-bit words,
// buffers them per lane and re-interleaves them strictly lane 0, lane 1, lane 0, ...
module phy_rx_unstripe #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in_0,
  input  logic        valid_in0,
  input  logic [7:0]  data_in_1,
  input  logic        valid_in1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        overflow_err,
  output logic        o_dbg_state
);

  localparam logic [0:0]     EXP_L0   = 1'b0;
  localparam logic [0:0]     EXP_L1   = 1'b1;
  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  // Packer state, per lane
  logic [1:0]       r_bcnt  [2];
  logic [23:0]      r_shift [2];

  // Lane FIFOs
  logic [31:0]      r_mem   [2][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr    [2];
  logic [PTR_W-1:0] r_rd    [2];
  logic [PTR_W:0]   r_count [2];

  logic [0:0]       r_state;
  logic [31:0]      r_data;
  logic             r_valid;
  logic             r_ovf;

  logic [7:0]       w_din   [2];
  logic [31:0]      w_word  [2];
  logic [1:0]       w_vin;
  logic [1:0]       w_push;
  logic [1:0]       w_empty;
  logic [1:0]       w_full;
  logic [1:0]       w_pop;
  logic [1:0]       w_acc;
  logic [1:0]       w_drop;

  assign w_din[0] = data_in_0;
  assign w_din[1] = data_in_1;
  assign w_vin    = {valid_in1, valid_in0};

  // A push into a full FIFO is only accepted when the same edge frees a slot.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      w_word[l]  = {r_shift[l], w_din[l]};
      w_push[l]  = w_vin[l] && (r_bcnt[l] == 2'd3);
      w_empty[l] = (r_count[l] == '0);
      w_full[l]  = (r_count[l] == LP_DEPTH);
      w_pop[l]   = !w_empty[l] && (r_state == 1'(l));
      w_acc[l]   = w_push[l] && (!w_full[l] || w_pop[l]);
      w_drop[l]  = w_push[l] && w_full[l] && !w_pop[l];
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        r_bcnt[l]  <= '0;
        r_shift[l] <= '0;
        r_wr[l]    <= '0;
        r_rd[l]    <= '0;
        r_count[l] <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (w_vin[l]) begin
          r_bcnt[l]  <= r_bcnt[l] + 2'd1;
          r_shift[l] <= {r_shift[l][15:0], w_din[l]};
        end
        if (w_acc[l]) r_wr[l] <= r_wr[l] + PTR_W'(1);
        if (w_pop[l]) r_rd[l] <= r_rd[l] + PTR_W'(1);
        case ({w_acc[l], w_pop[l]})
          2'b10:   r_count[l] <= r_count[l] + (PTR_W+1)'(1);
          2'b01:   r_count[l] <= r_count[l] - (PTR_W+1)'(1);
          default: r_count[l] <= r_count[l];
        endcase
      end
    end
  end

  // Storage needs no reset; emptiness is tracked by the occupancy counters.
  always_ff @(posedge clk_4f) begin
    for (int l = 0; l < 2; l++) begin
      if (w_acc[l]) r_mem[l][r_wr[l]] <= w_word[l];
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_state <= EXP_L0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (|w_drop) r_ovf <= 1'b1;
      case (r_state)
        EXP_L0: if (w_pop[0]) begin
          r_data  <= r_mem[0][r_rd[0]];
          r_valid <= 1'b1;
          r_state <= EXP_L1;
        end
        default: if (w_pop[1]) begin
          r_data  <= r_mem[1][r_rd[1]];
          r_valid <= 1'b1;
          r_state <= EXP_L0;
        end
      endcase
    end
  end

  assign data_out     = r_data;
  assign valid_out    = r_valid;
  assign overflow_err = r_ovf;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_phy_rx_unstripe.sv
// Bench for phy_rx_unstripe: directed scenarios plus randomized traffic
// against a queue-based model of the packing, buffering and alternation rules.
module tb_phy_rx_unstripe;

  localparam int DEPTH = 4;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  data_in_0, data_in_1;
  logic        valid_in0, valid_in1;
  logic [31:0] data_out;
  logic        valid_out, overflow_err, dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model
  logic [7:0]  m_b0[$], m_b1[$];
  logic [31:0] m_f0[$], m_f1[$];
  bit          m_lane;
  logic [31:0] m_data;
  bit          m_valid, m_ovf;
  logic [31:0] exp_q[$];

  phy_rx_unstripe #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_in_0(data_in_0), .valid_in0(valid_in0),
    .data_in_1(data_in_1), .valid_in1(valid_in1),
    .data_out(data_out), .valid_out(valid_out),
    .overflow_err(overflow_err), .o_dbg_state(dbg_state)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic model_clear();
    m_b0.delete(); m_b1.delete(); m_f0.delete(); m_f1.delete(); exp_q.delete();
    m_lane = 0; m_data = '0; m_valid = 0; m_ovf = 0;
  endtask

  // Output side decides from the occupancy seen before the edge, then new words land.
  task automatic model_edge(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
    logic [31:0] w;
    m_valid = 0;
    if (!m_lane && m_f0.size() > 0) begin
      m_data = m_f0.pop_front(); m_valid = 1; m_lane = 1;
    end else if (m_lane && m_f1.size() > 0) begin
      m_data = m_f1.pop_front(); m_valid = 1; m_lane = 0;
    end
    if (v0) begin
      m_b0.push_back(d0);
      if (m_b0.size() == 4) begin
        w = {m_b0[0], m_b0[1], m_b0[2], m_b0[3]};
        m_b0.delete();
        if (m_f0.size() < DEPTH) m_f0.push_back(w); else m_ovf = 1;
      end
    end
    if (v1) begin
      m_b1.push_back(d1);
      if (m_b1.size() == 4) begin
        w = {m_b1[0], m_b1[1], m_b1[2], m_b1[3]};
        m_b1.delete();
        if (m_f1.size() < DEPTH) m_f1.push_back(w); else m_ovf = 1;
      end
    end
  endtask

  task automatic tick(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
    valid_in0 = v0; data_in_0 = d0;
    valid_in1 = v1; data_in_1 = d1;
    @(posedge clk_4f);
    model_edge(v0, d0, v1, d1);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 8'($urandom), 1'b0, 8'($urandom));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in0 = 0; valid_in1 = 0; data_in_0 = '0; data_in_1 = '0;
    model_clear();
    #3;
    n_checks++;
    if ({data_out, valid_out, overflow_err, dbg_state} !== 35'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got data=%h v=%b ovf=%b st=%b, want all zero",
               data_out, valid_out, overflow_err, dbg_state);
    end
    #3 reset = 1'b0;
    @(posedge clk_4f); #1;
  endtask

  task automatic test_simultaneous();
    logic [7:0] b0[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] b1[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bit exp_v;
    logic [31:0] exp_d;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c < 4) tick(1'b1, b0[c], 1'b1, b1[c]); else idle();
      exp_v = (c + 1 == 5) || (c + 1 == 6);
      exp_d = (c + 1 == 5) ? 32'h11223344 : 32'hAABBCCDD;
      n_checks++;
      if (valid_out !== exp_v || (exp_v && data_out !== exp_d) || overflow_err !== 1'b0) begin
        n_errors++;
        $display("FAIL simultaneous cycle %0d: got v=%b d=%h ovf=%b, want v=%b d=%h ovf=0",
                 c + 1, valid_out, data_out, overflow_err, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_valid_gaps();
    bit         v[7] = '{1, 0, 1, 1, 0, 0, 1};
    logic [7:0] d[7] = '{8'h01, 8'hEE, 8'h02, 8'h03, 8'hEE, 8'hEE, 8'h04};
    bit exp_v;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      if (c < 7) tick(v[c], d[c], 1'b0, 8'h00); else idle();
      exp_v = (c + 1 == 8);
      n_checks++;
      if (valid_out !== exp_v || (exp_v && data_out !== 32'h01020304)) begin
        n_errors++;
        $display("FAIL valid_gaps cycle %0d: got v=%b d=%h, want v=%b d=01020304",
                 c + 1, valid_out, data_out, exp_v);
      end
    end
  endtask

  task automatic test_lane1_wait();
    logic [31:0] w1[4];
    logic [7:0]  b;
    logic [7:0]  l0[4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    bit exp_v;
    logic [31:0] exp_d;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      w1[i/4] = {w1[i/4][23:0], b};
      tick(1'b0, 8'h00, 1'b1, b);
      n_checks++;
      if (valid_out !== 1'b0) begin
        n_errors++;
        $display("FAIL lane1_wait_hold byte %0d: got v=%b, want v=0", i, valid_out);
      end
    end
    for (int p = 0; p < 12; p++) begin
      if (p < 4) tick(1'b1, l0[p], 1'b0, 8'h00); else idle();
      exp_v = (p == 4) || (p == 5);
      exp_d = (p == 4) ? 32'hCAFEF00D : w1[0];
      n_checks++;
      if (valid_out !== exp_v || (exp_v && data_out !== exp_d)) begin
        n_errors++;
        $display("FAIL lane1_wait_release step %0d: got v=%b d=%h, want v=%b d=%h",
                 p, valid_out, data_out, exp_v, exp_d);
      end
    end
    n_checks++;
    if (dbg_state !== 1'b0 || overflow_err !== 1'b0) begin
      n_errors++;
      $display("FAIL lane1_wait_final: got st=%b ovf=%b, want st=0 ovf=0", dbg_state, overflow_err);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w1[5];
    logic [31:0] w0;
    logic [31:0] got;
    logic [7:0]  b;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      w1[i/4] = {w1[i/4][23:0], b};
      tick(1'b0, 8'h00, 1'b1, b);
      n_checks++;
      if (overflow_err !== (i == 19)) begin
        n_errors++;
        $display("FAIL overflow_flag byte %0d: got ovf=%b, want %b", i, overflow_err, i == 19);
      end
    end
    for (int k = 0; k < 4; k++) begin
      w0 = $urandom;
      exp_q.push_back(w0);
      exp_q.push_back(w1[k]);
      for (int j = 0; j < 4; j++) begin
        tick(1'b1, w0[31-8*j -: 8], 1'b0, 8'h00);
        if (valid_out === 1'b1) begin
          got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
          n_checks++;
          if (data_out !== got) begin
            n_errors++;
            $display("FAIL overflow_drain: got %h, want %h", data_out, got);
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      idle();
      if (valid_out === 1'b1) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (data_out !== got) begin
          n_errors++;
          $display("FAIL overflow_drain_tail: got %h, want %h", data_out, got);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || overflow_err !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_final: got pending=%0d ovf=%b, want pending=0 ovf=1",
               exp_q.size(), overflow_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] c[4] = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [7:0] f[4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    bit exp_v;
    apply_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, a[i], 1'b1, c[i]);
    for (int i = 0; i < 3; i++) idle();
    for (int i = 0; i < 4; i++) tick(i < 2, 8'hA0 + 8'(i), 1'b1, 8'($urandom));
    #2 reset = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if ({data_out, valid_out, overflow_err, dbg_state} !== 35'd0) begin
      n_errors++;
      $display("FAIL reset_mid_async: got data=%h v=%b ovf=%b st=%b, want all zero",
               data_out, valid_out, overflow_err, dbg_state);
    end
    #2 reset = 1'b0;
    for (int p = 0; p < 10; p++) begin
      if (p < 4) tick(1'b1, f[p], 1'b0, 8'h00); else idle();
      exp_v = (p == 4);
      n_checks++;
      if (valid_out !== exp_v || (exp_v && data_out !== 32'h55667788)) begin
        n_errors++;
        $display("FAIL reset_mid_after step %0d: got v=%b d=%h, want v=%b d=55667788",
                 p, valid_out, data_out, exp_v);
      end
    end
  endtask

  task automatic test_balanced();
    int bi = 0;
    int rx = 0;
    logic [31:0] want;
    apply_reset();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
      exp_q.push_back(~{8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
    end
    for (int cyc = 0; cyc < 2000 && (bi < 256 || cyc < bi + 600); cyc++) begin
      if (bi < 256 && $urandom_range(3) != 0) begin
        tick(1'b1, 8'(bi), 1'b1, ~8'(bi));
        bi++;
      end else begin
        idle();
      end
      n_checks++;
      if ({valid_out, data_out, overflow_err} !== {m_valid, m_data, m_ovf}) begin
        n_errors++;
        $display("FAIL balanced_model: got v=%b d=%h ovf=%b, want v=%b d=%h ovf=%b",
                 valid_out, data_out, overflow_err, m_valid, m_data, m_ovf);
      end
      if (valid_out === 1'b1) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        rx++;
        n_checks++;
        if (data_out !== want) begin
          n_errors++;
          $display("FAIL balanced_order word %0d: got %h, want %h", rx, data_out, want);
        end
      end
      if (bi >= 256 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (rx != 128 || overflow_err !== 1'b0) begin
      n_errors++;
      $display("FAIL balanced_final: got words=%0d ovf=%b, want words=128 ovf=0", rx, overflow_err);
    end
  endtask

  task automatic test_random();
    bit v0, v1;
    int bias;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bias = (cyc < 200) ? 1 : 3;
      v0 = ($urandom_range(3) < bias);
      v1 = ($urandom_range(3) < 4 - bias);
      tick(v0, 8'($urandom), v1, 8'($urandom));
      n_checks++;
      if ({valid_out, data_out, overflow_err} !== {m_valid, m_data, m_ovf}) begin
        n_errors++;
        $display("FAIL random_model cycle %0d: got v=%b d=%h ovf=%b, want v=%b d=%h ovf=%b",
                 cyc, valid_out, data_out, overflow_err, m_valid, m_data, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_valid_gaps();
    test_lane1_wait();
    test_overflow();
    test_reset_mid();
    test_balanced();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
